// File: rtl/rv32i_pipe_ctrl_pkg.sv
// Shared definitions for the RV32I pipeline control slice: stage indices,
// sequencer state encoding and a stage-mask helper.
package rv32i_pipe_ctrl_pkg;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  typedef enum logic {
    PC_RUN,
    PC_FLUSH
  } pipe_ctrl_state_t;

  // Bits [hi:0] set; callers truncate to their stage count.
  function automatic logic [31:0] stage_mask_upto(input int hi);
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < 32; k++) begin
      if (k <= hi) m[k] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/rv32i_pipe_ctrl_event_counter.sv
// Free-running event counter: +1 per cycle with i_inc high, wraps modulo 2^CNT_W.
module rv32i_event_counter #(
  parameter int CNT_W = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/rv32i_pipe_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I core: merges stage stall requests,
// EX redirects and WB traps into per-stage stall/flush and the fetch PC load.
module rv32i_pipe_ctrl
  import rv32i_pipe_ctrl_pkg::*;
#(
  parameter int NUM_STAGES   = 5,
  parameter int ALU_STAGE    = STG_EX,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NUM_STAGES-1:0] i_stall_req,
  input  logic                  i_force_stall,
  input  logic                  i_change_pc,
  input  logic [31:0]           i_next_pc,
  input  logic                  i_trap,
  input  logic [31:0]           i_trap_pc,
  output logic [NUM_STAGES-1:0] o_stall,
  output logic [NUM_STAGES-1:0] o_flush,
  output logic                  o_pc_load,
  output logic [31:0]           o_pc_target,
  output logic                  o_busy,
  output logic [CNT_W-1:0]      o_stall_cycles,
  output logic [CNT_W-1:0]      o_redirects
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FC_W-1:0]       FC_RELOAD  = FC_W'(FLUSH_CYCLES - 1);
  localparam logic [NUM_STAGES-1:0] REDIR_MASK = NUM_STAGES'(stage_mask_upto(ALU_STAGE));
  localparam logic [NUM_STAGES-1:0] TRAP_MASK  = '1;

  pipe_ctrl_state_t      r_state;
  logic [FC_W-1:0]       r_cnt;
  logic [NUM_STAGES-1:0] r_mask;
  logic [31:0]           r_target;
  logic                  r_pc_load;

  logic [NUM_STAGES-1:0] w_flush;
  logic [NUM_STAGES-1:0] w_eff_req;
  logic [NUM_STAGES-1:0] w_stall;
  logic                  w_any_above;
  logic                  w_accept_trap;
  logic                  w_accept_redir;
  logic                  w_accept;

  assign w_flush   = (r_state == PC_FLUSH) ? r_mask : '0;
  assign w_eff_req = i_stall_req & ~w_flush;

  // A request at stage j freezes every younger stage 0..j as well.
  always_comb begin
    w_any_above = 1'b0;
    w_stall     = '0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      w_any_above = w_any_above | w_eff_req[k];
      w_stall[k]  = i_force_stall | w_any_above;
    end
  end

  // Traps always win; a redirect needs a running pipe and an unstalled EX.
  assign w_accept_trap  = i_trap;
  assign w_accept_redir = (r_state == PC_RUN) & i_change_pc & ~w_stall[ALU_STAGE] & ~i_trap;
  assign w_accept       = w_accept_trap | w_accept_redir;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= PC_RUN;
      r_cnt     <= '0;
      r_mask    <= '0;
      r_target  <= '0;
      r_pc_load <= 1'b0;
    end else begin
      r_pc_load <= w_accept;
      if (w_accept) begin
        r_state  <= PC_FLUSH;
        r_cnt    <= FC_RELOAD;
        r_mask   <= w_accept_trap ? TRAP_MASK : REDIR_MASK;
        r_target <= w_accept_trap ? i_trap_pc : i_next_pc;
      end else begin
        case (r_state)
          PC_RUN: begin
            r_state <= PC_RUN;
          end
          PC_FLUSH: begin
            // A debug freeze holds the flush window open.
            if (!i_force_stall) begin
              if (r_cnt == '0) begin
                r_state <= PC_RUN;
              end else begin
                r_cnt <= r_cnt - FC_W'(1);
              end
            end
          end
          default: begin
            r_state <= PC_RUN;
          end
        endcase
      end
    end
  end

  rv32i_event_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (|w_stall),
    .o_count (o_stall_cycles)
  );

  rv32i_event_counter #(.CNT_W(CNT_W)) u_redir_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (w_accept),
    .o_count (o_redirects)
  );

  assign o_stall     = w_stall;
  assign o_flush     = w_flush;
  assign o_pc_load   = r_pc_load;
  assign o_pc_target = r_target;
  assign o_busy      = (r_state == PC_FLUSH);

endmodule

// File: tb/tb_rv32i_pipe_ctrl.sv
// Self-checking bench for rv32i_pipe_ctrl: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_rv32i_pipe_ctrl;

  localparam int NS = 5;
  localparam int FC = 2;
  localparam int CW = 8;
  localparam int CNT_MOD = 1 << CW;

  logic          clk;
  logic          rst_n;
  logic [NS-1:0] stall_req;
  logic          force_stall;
  logic          change_pc;
  logic [31:0]   next_pc;
  logic          trap;
  logic [31:0]   trap_pc;
  logic [NS-1:0] o_stall;
  logic [NS-1:0] o_flush;
  logic          o_pc_load;
  logic [31:0]   o_pc_target;
  logic          o_busy;
  logic [CW-1:0] o_stall_cycles;
  logic [CW-1:0] o_redirects;

  rv32i_pipe_ctrl #(.NUM_STAGES(NS), .ALU_STAGE(2), .FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_stall_req    (stall_req),
    .i_force_stall  (force_stall),
    .i_change_pc    (change_pc),
    .i_next_pc      (next_pc),
    .i_trap         (trap),
    .i_trap_pc      (trap_pc),
    .o_stall        (o_stall),
    .o_flush        (o_flush),
    .o_pc_load      (o_pc_load),
    .o_pc_target    (o_pc_target),
    .o_busy         (o_busy),
    .o_stall_cycles (o_stall_cycles),
    .o_redirects    (o_redirects)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: remaining flush cycles (0 = running), latched mask/target, counters.
  int            m_flush_left;
  logic [NS-1:0] m_mask;
  logic [31:0]   m_target;
  logic          m_pc_load;
  int            m_stall_cnt;
  int            m_redir_cnt;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [NS-1:0] model_flush();
    return (m_flush_left > 0) ? m_mask : '0;
  endfunction

  function automatic logic [NS-1:0] model_stall(input logic [NS-1:0] req, input logic frz);
    logic [NS-1:0] fl;
    logic [NS-1:0] s;
    fl = model_flush();
    s  = '0;
    for (int k = 0; k < NS; k++) begin
      s[k] = frz;
      for (int j = k; j < NS; j++) begin
        if (req[j] && !fl[j]) s[k] = 1'b1;
      end
    end
    return s;
  endfunction

  task automatic model_reset();
    m_flush_left = 0;
    m_mask       = '0;
    m_target     = '0;
    m_pc_load    = 1'b0;
    m_stall_cnt  = 0;
    m_redir_cnt  = 0;
  endtask

  task automatic check_all(input string tag);
    check_val({tag, ".stall"},  32'(o_stall),        32'(model_stall(stall_req, force_stall)));
    check_val({tag, ".flush"},  32'(o_flush),        32'(model_flush()));
    check_val({tag, ".busy"},   32'(o_busy),         32'(m_flush_left > 0));
    check_val({tag, ".load"},   32'(o_pc_load),      32'(m_pc_load));
    check_val({tag, ".target"}, o_pc_target,         m_target);
    check_val({tag, ".stcnt"},  32'(o_stall_cycles), 32'(m_stall_cnt));
    check_val({tag, ".rdcnt"},  32'(o_redirects),    32'(m_redir_cnt));
  endtask

  // Drive one cycle's inputs, check current outputs, advance the model past the next edge.
  task automatic step(input string tag, input logic [NS-1:0] req, input logic frz,
                      input logic chg, input logic [31:0] npc,
                      input logic trp, input logic [31:0] tpc);
    logic [NS-1:0] st;
    logic          redir;
    @(negedge clk);
    stall_req   = req;
    force_stall = frz;
    change_pc   = chg;
    next_pc     = npc;
    trap        = trp;
    trap_pc     = tpc;
    #1;
    check_all(tag);
    st    = model_stall(req, frz);
    redir = (m_flush_left == 0) && chg && !st[2] && !trp;
    if (|st) m_stall_cnt = (m_stall_cnt + 1) % CNT_MOD;
    if (trp || redir) begin
      m_pc_load    = 1'b1;
      m_target     = trp ? tpc : npc;
      m_mask       = trp ? 5'b11111 : 5'b00111;
      m_flush_left = FC;
      m_redir_cnt  = (m_redir_cnt + 1) % CNT_MOD;
    end else begin
      m_pc_load = 1'b0;
      if (m_flush_left > 0 && !frz) m_flush_left--;
    end
  endtask

  task automatic idle(input string tag);
    step(tag, '0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic peek_after_edge();
    @(posedge clk);
    #1;
  endtask

  int base;

  initial begin
    rst_n = 1'b0; stall_req = '0; force_stall = 1'b0; change_pc = 1'b0;
    next_pc = '0; trap = 1'b0; trap_pc = '0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle("init");

    // Stall propagation and force stall
    base = m_stall_cnt;
    step("stall3", 5'b01000, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    check_val("stall3.vec", 32'(o_stall), 32'h0F);
    check_val("stall3.flush", 32'(o_flush), 32'h0);
    step("force", 5'b01000, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    check_val("force.vec", 32'(o_stall), 32'h1F);
    peek_after_edge();
    check_val("stall.count2", 32'(o_stall_cycles), 32'((base + 2) % CNT_MOD));

    // Plain redirect
    idle("pre_redir");
    base = m_redir_cnt;
    step("redir", '0, 1'b0, 1'b1, 32'h0000_0100, 1'b0, 32'h0);
    peek_after_edge();
    check_val("redir.load", 32'(o_pc_load), 32'h1);
    check_val("redir.target", o_pc_target, 32'h100);
    check_val("redir.flush1", 32'(o_flush), 32'h07);
    check_val("redir.count", 32'(o_redirects), 32'((base + 1) % CNT_MOD));
    idle("redir.f1");
    peek_after_edge();
    check_val("redir.flush2", 32'(o_flush), 32'h07);
    check_val("redir.load_once", 32'(o_pc_load), 32'h0);
    idle("redir.f2");
    peek_after_edge();
    check_val("redir.flush_end", 32'(o_flush), 32'h0);

    // Redirect deferred by a MEM stall
    for (int i = 0; i < 3; i++) begin
      step("defer", 5'b01000, 1'b0, 1'b1, 32'h0000_0200, 1'b0, 32'h0);
      peek_after_edge();
      check_val("defer.no_load", 32'(o_pc_load), 32'h0);
    end
    step("release", '0, 1'b0, 1'b1, 32'h0000_0200, 1'b0, 32'h0);
    peek_after_edge();
    check_val("release.load", 32'(o_pc_load), 32'h1);
    check_val("release.target", o_pc_target, 32'h200);
    idle("release.f1");
    idle("release.f2");

    // Simultaneous trap and redirect
    base = m_redir_cnt;
    step("trap_redir", '0, 1'b0, 1'b1, 32'h0000_0300, 1'b1, 32'h8000_0000);
    peek_after_edge();
    check_val("trap.target", o_pc_target, 32'h8000_0000);
    check_val("trap.flush", 32'(o_flush), 32'h1F);
    check_val("trap.count", 32'(o_redirects), 32'((base + 1) % CNT_MOD));
    idle("trap.f1");
    idle("trap.f2");

    // Trap in second flush cycle restarts the window
    step("rt.redir", '0, 1'b0, 1'b1, 32'h0000_0400, 1'b0, 32'h0);
    idle("rt.f1");
    step("rt.trap", '0, 1'b0, 1'b0, 32'h0, 1'b1, 32'hDEAD_0000);
    peek_after_edge();
    check_val("rt.load", 32'(o_pc_load), 32'h1);
    check_val("rt.flush", 32'(o_flush), 32'h1F);
    check_val("rt.target", o_pc_target, 32'hDEAD_0000);
    idle("rt.f2");
    idle("rt.f3");
    peek_after_edge();
    check_val("rt.flush_end", 32'(o_flush), 32'h0);

    // Stall counter wrap under force stall
    for (int i = 0; i < CNT_MOD && m_stall_cnt != CNT_MOD - 1; i++)
      step("wrap.fill", '0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    peek_after_edge();
    check_val("wrap.max", 32'(o_stall_cycles), 32'(CNT_MOD - 1));
    step("wrap.last", '0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    peek_after_edge();
    check_val("wrap.zero", 32'(o_stall_cycles), 32'h0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [NS-1:0] r;
      for (int b = 0; b < NS; b++) r[b] = ($urandom_range(0, 9) == 0);
      step("rand", r, ($urandom_range(0, 11) == 0), ($urandom_range(0, 2) == 0),
           $urandom, ($urandom_range(0, 12) == 0), $urandom);
    end

    // Asynchronous reset in the middle of a flush
    step("rst.redir", '0, 1'b0, 1'b1, 32'h0000_0500, 1'b0, 32'h0);
    peek_after_edge();
    check_val("rst.busy_before", 32'(o_busy), 32'h1);
    idle("rst.f1");
    stall_req = '0; force_stall = 1'b0; change_pc = 1'b0; trap = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check_val("rst.flush", 32'(o_flush), 32'h0);
    check_val("rst.load", 32'(o_pc_load), 32'h0);
    check_val("rst.target", o_pc_target, 32'h0);
    check_val("rst.busy", 32'(o_busy), 32'h0);
    check_val("rst.stcnt", 32'(o_stall_cycles), 32'h0);
    check_val("rst.rdcnt", 32'(o_redirects), 32'h0);
    check_val("rst.stall", 32'(o_stall), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle("post_rst");
    idle("post_rst2");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
